// File: rtl/multadd_arbiter.sv
// Round-robin arbiter sharing one multi-cycle signed multiply-add (p = a*b + c) among N_REQ requesters.
// Define MULTADD_ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin group.
module multadd_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_WAIT = 4,
  parameter int OP_W   = 35,
  parameter int ACC_W  = 70
) (
  input  logic                     clk_in,
  input  logic                     rstn_in,
  input  logic [N_REQ-1:0]         req_in,
  input  logic [N_REQ*OP_W-1:0]    a_in,
  input  logic [N_REQ*OP_W-1:0]    b_in,
  input  logic [N_REQ*ACC_W-1:0]   c_in,
  output logic [N_REQ-1:0]         gnt_out,
  output logic [N_REQ-1:0]         done_out,
  output logic signed [ACC_W-1:0]  p_out,
  output logic                     busy_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = 4;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                   state, state_nx;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic [IDX_W-1:0]         rr, rr_nx;
  logic [IDX_W-1:0]         win, win_nx;
  logic [N_REQ-1:0]         gnt_nx, done_nx;
  logic                     busy_nx;
  logic signed [ACC_W-1:0]  p_nx;

  logic signed [OP_W-1:0]   a_p0, b_p0;
  logic signed [ACC_W-1:0]  c_p0;

  logic [N_REQ-1:0]         elig, cand;
  logic                     pick_vld;
  logic [IDX_W-1:0]         pick_idx;
  logic                     issue;

  // Full-width signed multiply-add; wraps modulo 2^ACC_W, never saturates.
  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [OP_W-1:0]  a,
    input logic signed [OP_W-1:0]  b,
    input logic signed [ACC_W-1:0] c
  );
    logic signed [ACC_W-1:0] a_x, b_x;
    a_x = {{(ACC_W-OP_W){a[OP_W-1]}}, a};
    b_x = {{(ACC_W-OP_W){b[OP_W-1]}}, b};
    return a_x * b_x + c;
  endfunction

  // The requester currently pulsing done is masked so it cannot be re-granted in its done cycle.
  always_comb begin
    int j;
    j        = 0;
    elig     = req_in & ~done_out;
    pick_vld = 1'b0;
    pick_idx = '0;
`ifdef MULTADD_ARB_PRIO0_EN
    cand = elig & ~N_REQ'(1);
    if (elig[0]) begin
      pick_vld = 1'b1;
      pick_idx = '0;
    end
`else
    cand = elig;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(rr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_vld && cand[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rr_nx    = rr;
    win_nx   = win;
    gnt_nx   = gnt_out;
    done_nx  = '0;
    busy_nx  = busy_out;
    p_nx     = p_out;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          issue    = 1'b1;
          win_nx   = pick_idx;
          gnt_nx   = N_REQ'(1) << pick_idx;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(N_WAIT-1)) begin
          p_nx     = mac(a_p0, b_p0, c_p0);
          done_nx  = gnt_out;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
`ifdef MULTADD_ARB_PRIO0_EN
          if (win != '0)
            rr_nx = (win == IDX_W'(N_REQ-1)) ? '0 : win + IDX_W'(1);
`else
          rr_nx = (win == IDX_W'(N_REQ-1)) ? '0 : win + IDX_W'(1);
`endif
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state    <= IDLE;
      cnt      <= '0;
      rr       <= '0;
      win      <= '0;
      gnt_out  <= '0;
      done_out <= '0;
      busy_out <= 1'b0;
      p_out    <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rr       <= rr_nx;
      win      <= win_nx;
      gnt_out  <= gnt_nx;
      done_out <= done_nx;
      busy_out <= busy_nx;
      p_out    <= p_nx;
    end
  end

  // Stage p0: winner's operands captured once at issue; later input changes are ignored.
  always_ff @(posedge clk_in) begin
    if (issue) begin
      a_p0 <= a_in[int'(pick_idx)*OP_W +: OP_W];
      b_p0 <= b_in[int'(pick_idx)*OP_W +: OP_W];
      c_p0 <= c_in[int'(pick_idx)*ACC_W +: ACC_W];
    end
  end

endmodule
